// File: rtl/vga_timing_controller.sv
// VGA timing controller.
// A free-running 2-bit phase counter divides the clock into 4-clock pixel
// slots. Every slot issues a one-clock fetch strobe (req) with the fetch
// position. Blanking slots fetch position (0,0) so the generator pipeline
// keeps flushing. The pixel returned for slot s is sampled at the edge that
// ends phase 2 of slot s+1. Colour and both syncs update together at that
// edge, so the outputs trail the req cycle by a fixed 7 clocks.
//
// Phase numbering: the first clock edge after reset is released starts
// phase 0 of slot (0,0). The cycle directly after a reset edge still shows
// reset values. run_q marks that the sequence has started. This makes req,
// row, column and frame_start registered outputs that assert in the same
// cycle as phase 0.
module vga_timing_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       req,
  output logic [8:0] row,
  output logic [9:0] column,
  input  logic [7:0] VGAdata,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  localparam logic [1:0] PH_FETCH  = 2'd0;
  localparam logic [1:0] PH_SAMPLE = 2'd2;
  localparam logic [1:0] PH_LAST   = 2'd3;

  // Slot sequencing state.
  logic          run_q,   run_d;
  logic [1:0]    phase_q, phase_d;
  logic [HW-1:0] h_q,     h_d;
  logic [VW-1:0] v_q,     v_d;

  // Fetch-side registered outputs.
  logic          req_q,    req_d;
  logic [8:0]    row_q,    row_d;
  logic [9:0]    column_q, column_d;
  logic          fs_q,     fs_d;

  // Position attributes of the slot whose pixel is in flight.
  logic          p_vis_q, p_vis_d;
  logic          p_hs_q,  p_hs_d;
  logic          p_vs_q,  p_vs_d;

  // Display-side registered outputs.
  logic [2:0]    red_q,   red_d;
  logic [2:0]    green_q, green_d;
  logic [1:0]    blue_q,  blue_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  // Decoded helpers.
  logic          enter_fetch;
  logic          slot_end;
  logic          sample_edge;
  logic          next_vis;
  logic          cur_vis;
  logic          cur_hs_n;
  logic          cur_vs_n;

  // Edge classification: which edge of the slot the next clock is.
  always_comb begin
    slot_end    = run_q && (phase_q == PH_LAST);
    sample_edge = run_q && (phase_q == PH_SAMPLE);
    enter_fetch = !run_q || (phase_q == PH_LAST);
  end

  // Phase counter and h/v fetch counters; h/v advance only when a slot ends.
  always_comb begin
    run_d   = 1'b1;
    phase_d = run_q ? (phase_q + 2'd1) : PH_FETCH;
    h_d     = h_q;
    v_d     = v_q;
    if (slot_end) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Fetch strobe and fetch address for the slot that begins on the next edge.
  always_comb begin
    next_vis = (h_d < H_VIS_C) && (v_d < V_VIS_C);
    req_d    = enter_fetch;
    row_d    = row_q;
    column_d = column_q;
    fs_d     = enter_fetch && (h_d == '0) && (v_d == '0);
    if (enter_fetch) begin
      row_d    = next_vis ? 9'(v_d)  : 9'd0;
      column_d = next_vis ? 10'(h_d) : 10'd0;
    end
  end

  // Latch visibility and sync levels of the current slot as it ends.
  always_comb begin
    cur_vis  = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    cur_hs_n = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    cur_vs_n = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    p_vis_d  = p_vis_q;
    p_hs_d   = p_hs_q;
    p_vs_d   = p_vs_q;
    if (slot_end) begin
      p_vis_d = cur_vis;
      p_hs_d  = cur_hs_n;
      p_vs_d  = cur_vs_n;
    end
  end

  // At the phase-2 edge, colour and syncs update together for the previous slot.
  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (sample_edge) begin
      red_d   = p_vis_q ? VGAdata[7:5] : 3'd0;
      green_d = p_vis_q ? VGAdata[4:2] : 3'd0;
      blue_d  = p_vis_q ? VGAdata[1:0] : 2'd0;
      hsync_d = p_hs_q;
      vsync_d = p_vs_q;
    end
  end

  // Sequencing registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= 1'b0;
      phase_q <= PH_FETCH;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      run_q   <= run_d;
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Fetch-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      row_q    <= '0;
      column_q <= '0;
      fs_q     <= 1'b0;
    end else begin
      req_q    <= req_d;
      row_q    <= row_d;
      column_q <= column_d;
      fs_q     <= fs_d;
    end
  end

  // In-flight position pipeline; cleared so stale slots never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_vis_q <= 1'b0;
      p_hs_q  <= 1'b1;
      p_vs_q  <= 1'b1;
    end else begin
      p_vis_q <= p_vis_d;
      p_hs_q  <= p_hs_d;
      p_vs_q  <= p_vs_d;
    end
  end

  // Display-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign req         = req_q;
  assign row         = row_q;
  assign column      = column_q;
  assign frame_start = fs_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a reduced raster.
// The raster is 32 slots per line (16 visible, hsync on h 20..27) and
// 20 lines per frame (12 visible, vsync on v 14..15).
// Cycle c (c >= 1 after reset release) is slot k = (c-1)/4, phase (c-1)%4.
// Colour and syncs seen in cycle c belong to slot (c-8)/4.
module tb_vga_timing_controller;

  localparam int HV  = 16;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int VV  = 12;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req;
  logic [8:0] row;
  logic [9:0] column;
  logic [7:0] VGAdata = 8'h00;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_start;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  vga_timing_controller #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .row        (row),
    .column     (column),
    .VGAdata    (VGAdata),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_start(frame_start)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] gen_data(input logic [8:0] r, input logic [9:0] c);
    gen_data = (r == 9'd5 && c == 10'd10) ? 8'hE3 : 8'hFF;
  endfunction

  // Pixel generator: answers the previous request during phases 1..2 of the
  // following slot, and drives 00 elsewhere so a mistimed sample is visible.
  initial begin
    logic [8:0] cur_r, prev_r;
    logic [9:0] cur_c, prev_c;
    int gph;
    cur_r = '0; prev_r = '0; cur_c = '0; prev_c = '0; gph = 0;
    forever begin
      @(negedge clk);
      if (req) begin
        prev_r = cur_r;
        prev_c = cur_c;
        cur_r  = row;
        cur_c  = column;
        gph    = 0;
      end else begin
        gph++;
      end
      if (gph == 1) VGAdata = gen_data(prev_r, prev_c);
      else if (gph == 3) VGAdata = 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s (cycle %0d): got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the posedge that begins cycle c.
  task automatic goto(input int c);
    if (c > cyc) begin
      repeat (c - cyc) @(posedge clk);
      cyc = c;
      #1;
    end
  endtask

  function automatic logic [31:0] rgb();
    rgb = {24'd0, red, green, blue};
  endfunction

  initial begin
    // Reset held for 3 clocks.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",    req,         0);
    check("rst_row",    row,         0);
    check("rst_col",    column,      0);
    check("rst_fs",     frame_start, 0);
    check("rst_hsync",  hsync,       1);
    check("rst_vsync",  vsync,       1);
    check("rst_rgb",    rgb(),       0);
    rst = 1'b0;
    cyc = 0;

    goto(1);
    check("first_req", req,         1);
    check("first_row", row,         0);
    check("first_col", column,      0);
    check("first_fs",  frame_start, 1);
    check("first_rgb", rgb(),       0);
    check("first_hs",  hsync,       1);
    goto(2);
    check("c2_req", req,         0);
    check("c2_fs",  frame_start, 0);

    // First 14 slots of line 0: strobe cadence, column count, colour start.
    for (int c = 3; c <= 60; c++) begin
      goto(c);
      check("cad_req", req, ((c - 1) % 4 == 0) ? 1 : 0);
      if ((c - 1) % 4 == 0) begin
        check("cad_col", column, (c - 1) / 4);
        check("cad_row", row,    0);
      end
      check("cad_rgb", rgb(), (c < 8) ? 32'h0 : 32'hFF);
      check("cad_hs",  hsync, 1);
    end

    goto(61);   check("h15_col", column, 15); check("h15_req", req, 1);
    goto(65);   check("h16_col", column, 0);  check("h16_row", row, 0);
    goto(71);   check("h15_rgb", rgb(), 32'hFF);
    goto(72);   check("h16_rgb", rgb(), 0);
    goto(87);   check("hs_pre",  hsync, 1);
    goto(88);   check("hs_fall", hsync, 0);   check("hs_fall_rgb", rgb(), 0);
    goto(119);  check("hs_last", hsync, 0);
    goto(120);  check("hs_rise", hsync, 1);
    goto(129);  check("l1_req", req, 1); check("l1_row", row, 1);
                check("l1_col", column, 0); check("l1_fs", frame_start, 0);
    goto(681);  check("p510_row", row, 5); check("p510_col", column, 10);
    goto(687);  check("p509_rgb", rgb(), 32'hFF);
    goto(688);  check("p510_red", red, 7); check("p510_grn", green, 0);
                check("p510_blu", blue, 3);
    goto(1549); check("vb_req", req, 1); check("vb_row", row, 0);
                check("vb_col", column, 0);
    goto(1799); check("vs_pre",  vsync, 1);
    goto(1800); check("vs_fall", vsync, 0);
    goto(2055); check("vs_last", vsync, 0);
    goto(2056); check("vs_rise", vsync, 1);
    goto(2557); check("fs_prev", frame_start, 0); check("fs_prev_req", req, 1);
    goto(2561); check("fs2", frame_start, 1); check("fs2_row", row, 0);
                check("fs2_col", column, 0);
    goto(2562); check("fs2_end", frame_start, 0);

    // Mid-frame reset at v=7, h=10 of the second frame.
    goto(3497); check("mid_req", req, 1); check("mid_row", row, 7);
                check("mid_col", column, 10);
    goto(3498); check("mid_rgb", rgb(), 32'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check("mrst_req",   req,         0);
    check("mrst_fs",    frame_start, 0);
    check("mrst_rgb",   rgb(),       0);
    check("mrst_hsync", hsync,       1);
    check("mrst_vsync", vsync,       1);
    check("mrst_row",   row,         0);
    check("mrst_col",   column,      0);
    goto(1);    check("re_req", req, 1); check("re_fs", frame_start, 1);
                check("re_row", row, 0); check("re_col", column, 0);
    goto(5);    check("re_col1", column, 1); check("re_fs_off", frame_start, 0);
    goto(7);    check("re_rgb7", rgb(), 0);
    goto(8);    check("re_rgb8", rgb(), 32'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
